// File: rtl/board_mem_arbiter.sv
// rtl/board_mem_arbiter.sv - board RAM sharing between the display fetch path and game logic
module board_mem_arbiter #(
    parameter int BOARD_W    = 10,
    parameter int BOARD_H    = 20,
    parameter int CELL_SHIFT = 4,
    parameter int BOARD_X0   = 240,
    parameter int BOARD_Y0   = 80,
    parameter int COLOR_W    = 3,
    parameter int ADDR_W     = 8,
    parameter int BG_COLOR   = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [8:0]         row_i,
    input  logic [9:0]         column_i,
    input  logic               blank_n_i,
    input  logic               game_req_i,
    input  logic               game_we_i,
    input  logic [ADDR_W-1:0]  game_addr_i,
    input  logic [COLOR_W-1:0] game_wdata_i,
    output logic               game_gnt_o,
    output logic [COLOR_W-1:0] game_rdata_o,
    output logic               game_rvalid_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic               mem_we_o,
    output logic [COLOR_W-1:0] mem_wdata_o,
    input  logic [COLOR_W-1:0] mem_rdata_i,
    output logic [COLOR_W-1:0] pix_color_o
);

    localparam int BOARD_X1 = BOARD_X0 + (BOARD_W << CELL_SHIFT);
    localparam int BOARD_Y1 = BOARD_Y0 + (BOARD_H << CELL_SHIFT);
    localparam int CELLS    = BOARD_W * BOARD_H;
    localparam logic [15:0]        W_BITS = 16'(BOARD_W);
    localparam logic [COLOR_W-1:0] BG     = COLOR_W'(BG_COLOR);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               mem_we_q, mem_we_d;
    logic [COLOR_W-1:0] mem_wdata_q, mem_wdata_d;
    logic               gnt_rd_q, gnt_rd_d;
    logic               rd_ok_q, rd_ok_d;
    logic               rvalid_q, rvalid_d;
    logic               w_d1_q, w_d2_q;

    logic [31:0]        row_ext, col_ext;
    logic [31:0]        cell_y, cell_x, row_base;
    logic               in_win;
    logic               game_in_range;
    logic [ADDR_W-1:0]  disp_addr;

    // Board window test and cell index; the row*BOARD_W product is a shift-add over the constant's set bits
    always_comb begin
        row_ext  = 32'(row_i);
        col_ext  = 32'(column_i);
        in_win   = blank_n_i
                   && (row_ext >= 32'(BOARD_Y0)) && (row_ext < 32'(BOARD_Y1))
                   && (col_ext >= 32'(BOARD_X0)) && (col_ext < 32'(BOARD_X1));
        cell_y   = (row_ext - 32'(BOARD_Y0)) >> CELL_SHIFT;
        cell_x   = (col_ext - 32'(BOARD_X0)) >> CELL_SHIFT;
        row_base = 32'd0;
        for (int i = 0; i < 16; i++) begin
            if (W_BITS[i]) begin
                row_base = row_base + (cell_y << i);
            end
        end
        disp_addr     = ADDR_W'(row_base + cell_x);
        game_in_range = (32'(game_addr_i) < 32'(CELLS));
    end

    // Arbitration and next RAM command: display owns the bus in the window, game is served outside it
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        gnt_rd_d    = gnt_rd_q;
        rd_ok_d     = rd_ok_q;
        rvalid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!in_win && game_req_i) begin
                    state_d     = GRANT;
                    mem_addr_d  = game_addr_i;
                    mem_we_d    = game_we_i && game_in_range;
                    mem_wdata_d = game_wdata_i;
                    gnt_rd_d    = !game_we_i;
                    rd_ok_d     = game_in_range;
                end
            end
            GRANT: begin
                // No decision here, so grants are spaced at least two cycles apart
                state_d  = IDLE;
                rvalid_d = gnt_rd_q;
            end
            default: state_d = IDLE;
        endcase
        if (in_win) begin
            mem_addr_d = disp_addr;
            mem_we_d   = 1'b0;
        end
    end

    // State, RAM command and window pipeline registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            gnt_rd_q    <= 1'b0;
            rd_ok_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            w_d1_q      <= 1'b0;
            w_d2_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            gnt_rd_q    <= gnt_rd_d;
            rd_ok_q     <= rd_ok_d;
            rvalid_q    <= rvalid_d;
            w_d1_q      <= in_win;
            w_d2_q      <= w_d1_q;
        end
    end

    // Output mapping; out-of-range game reads return zero rather than RAM contents
    always_comb begin
        game_gnt_o    = (state_q == GRANT);
        game_rvalid_o = rvalid_q;
        game_rdata_o  = (rvalid_q && rd_ok_q) ? mem_rdata_i : '0;
        mem_addr_o    = mem_addr_q;
        mem_we_o      = mem_we_q;
        mem_wdata_o   = mem_wdata_q;
        pix_color_o   = w_d2_q ? mem_rdata_i : BG;
    end

endmodule
